// File: rtl/led_pattern_gen_if.sv
// Configuration write port of the LED pattern generator: one-cycle write
// strobe plus the channel select and the fields latched into that channel.
interface led_pattern_gen_if #(
  parameter int CH_W    = 2,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 4
);
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_on;
  logic [BURST_W-1:0] cfg_burst;

  // Config source (control FSM, bus bridge, testbench)
  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
    output cfg_on,
    output cfg_burst
  );

  // Pattern generator side
  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_mode,
    input cfg_period,
    input cfg_on,
    input cfg_burst
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator. A shared prescaler produces a one-cycle
// time-base tick every D = CLK_FREQ/TICK_FREQ clocks; each channel runs
// independently in off / on / blink / burst mode from its own latched config.
// The LED outputs are registered, one cycle behind the channel state.
module led_pattern_gen #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int BURST_W   = 4,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  led_pattern_gen_if.slave  cfg,
  output logic [N_CH-1:0]   led,
  output logic              tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  localparam int                D       = CLK_FREQ / TICK_FREQ;
  localparam int                PSC_W   = (D > 1) ? $clog2(D) : 1;
  localparam logic [PSC_W-1:0]  PSC_MAX = PSC_W'(D - 1);
  // Channel count widened by one bit so that N_CH itself is representable
  localparam logic [CH_W:0]     N_CH_V  = (CH_W + 1)'(N_CH);

  // Output function of one channel, evaluated on its registered state.
  // Blink: P < 2 degenerates to a constant (T != 0); otherwise on while
  // ph < T, which naturally yields constant 1 for T >= P and 0 for T = 0.
  // Burst: blink gated by bc < B, so bc = B is the dark period.
  function automatic logic pattern_f(
    input mode_e              m,
    input logic [CNT_W-1:0]   p,
    input logic [CNT_W-1:0]   t,
    input logic [CNT_W-1:0]   ph,
    input logic [BURST_W-1:0] b,
    input logic [BURST_W:0]   bc
  );
    logic blink_v;
    logic res_v;
    if (p < CNT_W'(2)) begin
      blink_v = (t != {CNT_W{1'b0}});
    end else begin
      blink_v = (ph < t);
    end
    case (m)
      MODE_OFF:   res_v = 1'b0;
      MODE_ON:    res_v = 1'b1;
      MODE_BLINK: res_v = blink_v;
      MODE_BURST: res_v = blink_v && (bc < {1'b0, b});
      default:    res_v = 1'b0;
    endcase
    return res_v;
  endfunction

  // Prescaler and tick
  logic [PSC_W-1:0]   psc_r;
  logic [PSC_W-1:0]   psc_nxt_s;
  logic               tick_r;
  logic               tick_nxt_s;

  // Per-channel state
  mode_e              mode_r     [N_CH];
  mode_e              mode_nxt_s [N_CH];
  logic [CNT_W-1:0]   p_r        [N_CH];
  logic [CNT_W-1:0]   p_nxt_s    [N_CH];
  logic [CNT_W-1:0]   t_r        [N_CH];
  logic [CNT_W-1:0]   t_nxt_s    [N_CH];
  logic [BURST_W-1:0] b_r        [N_CH];
  logic [BURST_W-1:0] b_nxt_s    [N_CH];
  logic [CNT_W-1:0]   ph_r       [N_CH];
  logic [CNT_W-1:0]   ph_nxt_s   [N_CH];
  logic [BURST_W:0]   bc_r       [N_CH];
  logic [BURST_W:0]   bc_nxt_s   [N_CH];

  // Outputs
  logic [N_CH-1:0]    led_r;
  logic [N_CH-1:0]    led_nxt_s;

  // Write decode
  logic               ch_ok_s;
  logic [N_CH-1:0]    wr_hit_s;

  // Prescaler: count 0..D-1, tick goes high for the cycle after the wrap
  always_comb begin
    psc_nxt_s  = psc_r + PSC_W'(1);
    tick_nxt_s = 1'b0;
    if (psc_r == PSC_MAX) begin
      psc_nxt_s  = {PSC_W{1'b0}};
      tick_nxt_s = 1'b1;
    end else begin
      psc_nxt_s  = psc_r + PSC_W'(1);
      tick_nxt_s = 1'b0;
    end
  end

  // Write decode: out-of-range channel numbers address nothing
  always_comb begin
    wr_hit_s = {N_CH{1'b0}};
    ch_ok_s  = ({1'b0, cfg.cfg_ch} < N_CH_V);
    for (int i = 0; i < N_CH; i++) begin
      if (cfg.cfg_we && ch_ok_s && (cfg.cfg_ch == CH_W'(i))) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
  end

  // Channel next state: a write beats a same-cycle tick on that channel only
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mode_nxt_s[i] = mode_r[i];
      p_nxt_s[i]    = p_r[i];
      t_nxt_s[i]    = t_r[i];
      b_nxt_s[i]    = b_r[i];
      ph_nxt_s[i]   = ph_r[i];
      bc_nxt_s[i]   = bc_r[i];

      if (wr_hit_s[i]) begin
        mode_nxt_s[i] = mode_e'(cfg.cfg_mode);
        p_nxt_s[i]    = cfg.cfg_period;
        t_nxt_s[i]    = cfg.cfg_on;
        b_nxt_s[i]    = cfg.cfg_burst;
        ph_nxt_s[i]   = {CNT_W{1'b0}};
        bc_nxt_s[i]   = {(BURST_W + 1){1'b0}};
      end else if ((mode_r[i] == MODE_OFF) || (mode_r[i] == MODE_ON)) begin
        ph_nxt_s[i]   = {CNT_W{1'b0}};
        bc_nxt_s[i]   = {(BURST_W + 1){1'b0}};
      end else if (tick_r) begin
        // P < 2 wraps on every tick; otherwise wrap at ph = P-1 (P-1 cannot
        // underflow on this branch)
        if ((p_r[i] < CNT_W'(2)) || (ph_r[i] >= (p_r[i] - CNT_W'(1)))) begin
          ph_nxt_s[i] = {CNT_W{1'b0}};
          if (mode_r[i] == MODE_BURST) begin
            if (bc_r[i] >= {1'b0, b_r[i]}) begin
              bc_nxt_s[i] = {(BURST_W + 1){1'b0}};
            end else begin
              bc_nxt_s[i] = bc_r[i] + (BURST_W + 1)'(1);
            end
          end else begin
            bc_nxt_s[i] = {(BURST_W + 1){1'b0}};
          end
        end else begin
          ph_nxt_s[i] = ph_r[i] + CNT_W'(1);
          bc_nxt_s[i] = bc_r[i];
        end
      end else begin
        ph_nxt_s[i]   = ph_r[i];
        bc_nxt_s[i]   = bc_r[i];
      end
    end
  end

  // LED drive computed from the registered channel state (one cycle latency)
  always_comb begin
    led_nxt_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      led_nxt_s[i] = pattern_f(mode_r[i], p_r[i], t_r[i], ph_r[i], b_r[i], bc_r[i]);
    end
  end

  // State registers with synchronous reset clearing every channel
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_r  <= {PSC_W{1'b0}};
      tick_r <= 1'b0;
      led_r  <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        mode_r[i] <= MODE_OFF;
        p_r[i]    <= {CNT_W{1'b0}};
        t_r[i]    <= {CNT_W{1'b0}};
        b_r[i]    <= {BURST_W{1'b0}};
        ph_r[i]   <= {CNT_W{1'b0}};
        bc_r[i]   <= {(BURST_W + 1){1'b0}};
      end
    end else begin
      psc_r  <= psc_nxt_s;
      tick_r <= tick_nxt_s;
      led_r  <= led_nxt_s;
      for (int i = 0; i < N_CH; i++) begin
        mode_r[i] <= mode_nxt_s[i];
        p_r[i]    <= p_nxt_s[i];
        t_r[i]    <= t_nxt_s[i];
        b_r[i]    <= b_nxt_s[i];
        ph_r[i]   <= ph_nxt_s[i];
        bc_r[i]   <= bc_nxt_s[i];
      end
    end
  end

  assign led  = led_r;
  assign tick = tick_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: D = 10 clocks per tick, 4 channels,
// 8-bit period fields, 3-bit burst count, channel select widened to 3 bits
// so that an out-of-range channel number can be driven.
module tb_led_pattern_gen;

  localparam int CLK_FREQ  = 1000;
  localparam int TICK_FREQ = 100;
  localparam int N_CH      = 4;
  localparam int CNT_W     = 8;
  localparam int BURST_W   = 3;
  localparam int CH_W      = 3;
  localparam int D         = CLK_FREQ / TICK_FREQ;

  typedef struct {
    logic       rst;
    logic       we;
    logic [2:0] ch;
    logic [1:0] mode;
    logic [7:0] p;
    logic [7:0] t;
    logic [2:0] b;
    int         n;        // edges this row spans (inputs applied on the first)
    logic [3:0] exp_led;  // led required after every edge of the row
  } vec_t;

  logic            clk;
  logic            reset;
  logic [N_CH-1:0] led;
  logic            tick;

  int n_checks;
  int n_err;
  int edge_no;
  int since_rst;

  vec_t vq[$];

  led_pattern_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  led_pattern_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_FREQ(TICK_FREQ),
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .BURST_W  (BURST_W),
    .CH_W     (CH_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cfg  (bus),
    .led  (led),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic we, input logic [2:0] ch,
                     input logic [1:0] mode, input logic [7:0] p, input logic [7:0] t,
                     input logic [2:0] b, input int n, input logic [3:0] exp_led);
    vec_t v;
    v.rst = r; v.we = we; v.ch = ch; v.mode = mode;
    v.p = p; v.t = t; v.b = b; v.n = n; v.exp_led = exp_led;
    vq.push_back(v);
  endtask

  // Drive inputs, take one rising edge, return on the following falling edge
  task automatic cycle(input logic r, input logic we, input logic [2:0] ch,
                       input logic [1:0] mode, input logic [7:0] p, input logic [7:0] t,
                       input logic [2:0] b);
    reset          = r;
    bus.cfg_we     = we;
    bus.cfg_ch     = ch;
    bus.cfg_mode   = mode;
    bus.cfg_period = p;
    bus.cfg_on     = t;
    bus.cfg_burst  = b;
    @(posedge clk);
    edge_no++;
    if (r) since_rst = 0;
    else   since_rst++;
    @(negedge clk);
  endtask

  // Compare led to the row value and tick to the D-cycle time base
  task automatic check(input string name, input logic [3:0] exp_led);
    logic exp_tick;
    exp_tick = (since_rst > 0) && ((since_rst % D) == 0);
    n_checks++;
    if (led !== exp_led) begin
      n_err++;
      $display("FAIL %s led edge=%0d got=%b want=%b", name, edge_no, led, exp_led);
    end
    n_checks++;
    if (tick !== exp_tick) begin
      n_err++;
      $display("FAIL %s tick edge=%0d got=%b want=%b", name, edge_no, tick, exp_tick);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    edge_no   = 0;
    since_rst = 0;

    // Edge numbers below count from the last reset edge (edge 0). Ticks are
    // high after edges 10, 20, ...; they advance phases at edges 11, 21, ...,
    // which is also where every write is placed (write must win).
    // Test 2: ch0 on, then off
    add(0, 1, 3'd0, 2'b01, 8'd0, 8'd0, 3'd0,  1, 4'b0000); // 31
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  4, 4'b0001); // 32..35
    add(0, 1, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  1, 4'b0001); // 36
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  4, 4'b0000); // 37..40
    // Test 3: ch1 blink P=4 T=1, then T=4, T=0, P=1 T=1
    add(0, 1, 3'd1, 2'b10, 8'd4, 8'd1, 3'd0,  1, 4'b0000); // 41
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0010); // 42..51
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 30, 4'b0000); // 52..81
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0010); // 82..91
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  9, 4'b0000); // 92..100
    add(0, 1, 3'd1, 2'b10, 8'd4, 8'd4, 3'd0,  1, 4'b0000); // 101
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 29, 4'b0010); // 102..130
    add(0, 1, 3'd1, 2'b10, 8'd4, 8'd0, 3'd0,  1, 4'b0010); // 131
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 19, 4'b0000); // 132..150
    add(0, 1, 3'd1, 2'b10, 8'd1, 8'd1, 3'd0,  1, 4'b0000); // 151
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 19, 4'b0010); // 152..170
    // Test 4: ch2 burst P=2 T=1 B=3 (ch1 stays constant on)
    add(0, 1, 3'd2, 2'b11, 8'd2, 8'd1, 3'd3,  1, 4'b0010); // 171
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0110); // 172..181
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0010); // 182..191
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0110); // 192..201
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0010); // 202..211
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0110); // 212..221
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 30, 4'b0010); // 222..251
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0110); // 252..261
    // ch3 burst with B=0 must stay dark
    add(0, 1, 3'd3, 2'b11, 8'd2, 8'd1, 3'd0,  1, 4'b0010); // 262
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  8, 4'b0010); // 263..270
    // Test 5: ch1 rewritten on a tick edge restarts at ph=0; ch2 keeps going
    add(0, 1, 3'd1, 2'b10, 8'd4, 8'd1, 3'd0,  1, 4'b0010); // 271
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0110); // 272..281
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0000); // 282..291
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0100); // 292..301
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0000); // 302..311
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0010); // 312..321
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0000); // 322..331
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  3, 4'b0100); // 332..334
    // cfg_ch=5 is out of range: ignored (would alias ch1 if truncated)
    add(0, 1, 3'd5, 2'b01, 8'd0, 8'd0, 3'd0,  1, 4'b0100); // 335
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  6, 4'b0100); // 336..341
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 10, 4'b0000); // 342..351
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0,  4, 4'b0110); // 352..355
    // Test 6: reset with a simultaneous write; everything dark afterwards
    add(1, 1, 3'd0, 2'b01, 8'd0, 8'd0, 3'd0,  1, 4'b0000); // 356
    add(0, 0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0, 44, 4'b0000); // 357..400

    // Test 1: three reset cycles, then time base and dark LEDs
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0);
    end
    edge_no = 0;
    check("reset", 4'b0000);
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0);
      check("timebase", 4'b0000);
    end

    // Tests 2..6 from the vector table
    foreach (vq[k]) begin
      cycle(vq[k].rst, vq[k].we, vq[k].ch, vq[k].mode, vq[k].p, vq[k].t, vq[k].b);
      check($sformatf("row%0d", k), vq[k].exp_led);
      for (int j = 1; j < vq[k].n; j++) begin
        cycle(1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 8'd0, 3'd0);
        check($sformatf("row%0d", k), vq[k].exp_led);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
